// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, issues ROM reads and hands each
// fetched word to the instruction register with a single-cycle load strobe.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Fetch,
  input  logic              PC_ld,
  input  logic [ADDR_W-1:0] Jump_addr,
  input  logic [15:0]       ROM_data,
  output logic [ADDR_W-1:0] ROM_addr,
  output logic              ROM_rd,
  output logic [15:0]       IR_data,
  output logic              IR_ld,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] PC
);

  localparam int unsigned CntW = 2;

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("instr_fetch: MEM_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StLoad} state_e;

  state_e            state_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [15:0]       ir_q;
  logic              done_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      pc_q       <= '0;
      rom_addr_q <= '0;
      ir_q       <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A jump taken together with a fetch reads the jump target.
          if (Fetch) begin
            state_q <= StIssue;
            if (PC_ld) begin
              pc_q       <= Jump_addr;
              rom_addr_q <= Jump_addr;
            end else begin
              rom_addr_q <= pc_q;
            end
          end else if (PC_ld) begin
            pc_q <= Jump_addr;
          end
        end
        StIssue: begin
          wait_cnt_q <= CntW'(MEM_LAT - 1);
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            ir_q    <= ROM_data;
            state_q <= StLoad;
          end else begin
            wait_cnt_q <= wait_cnt_q - CntW'(1);
          end
        end
        StLoad: begin
          pc_q    <= pc_q + ADDR_W'(1);
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ROM_addr = rom_addr_q;
  assign ROM_rd   = (state_q == StIssue);
  assign IR_data  = ir_q;
  assign IR_ld    = (state_q == StLoad);
  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign PC       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (MEM_LAT 1 and 3) against an edge-schedule
// reference model, with a latency-accurate ROM model feeding each instance.
module tb_instr_fetch;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Fetch;
  logic        PC_ld;
  logic [7:0]  Jump_addr;

  logic [15:0] rom_data [2];
  logic [7:0]  rom_addr [2];
  logic        rom_rd   [2];
  logic [15:0] ir_data  [2];
  logic        ir_ld    [2];
  logic        busy     [2];
  logic        done     [2];
  logic [7:0]  pc       [2];

  logic [15:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;
  int ecount = 0;

  // Reference model: per instance, the edge at which the current fetch was accepted.
  int          m_start [2] = '{-1, -1};
  logic [7:0]  m_pc    [2] = '{8'h00, 8'h00};
  logic [7:0]  m_ra    [2] = '{8'h00, 8'h00};
  logic [7:0]  m_fa    [2] = '{8'h00, 8'h00};
  logic [15:0] m_ir    [2] = '{16'h0000, 16'h0000};

  logic [15:0] ir_log [$];
  int          ir_edge [$];
  logic [7:0]  ra_log [$];

  logic [7:0]  pend_addr [2];
  int          pend_cnt  [2] = '{0, 0};

  always #5 Clock = ~Clock;

  instr_fetch #(.ADDR_W(8), .MEM_LAT(1)) dut_lat1 (
    .Clock(Clock), .Reset(Reset), .Fetch(Fetch), .PC_ld(PC_ld), .Jump_addr(Jump_addr),
    .ROM_data(rom_data[0]), .ROM_addr(rom_addr[0]), .ROM_rd(rom_rd[0]),
    .IR_data(ir_data[0]), .IR_ld(ir_ld[0]), .Busy(busy[0]), .Done(done[0]), .PC(pc[0])
  );

  instr_fetch #(.ADDR_W(8), .MEM_LAT(3)) dut_lat3 (
    .Clock(Clock), .Reset(Reset), .Fetch(Fetch), .PC_ld(PC_ld), .Jump_addr(Jump_addr),
    .ROM_data(rom_data[1]), .ROM_addr(rom_addr[1]), .ROM_rd(rom_rd[1]),
    .IR_data(ir_data[1]), .IR_ld(ir_ld[1]), .Busy(busy[1]), .Done(done[1]), .PC(pc[1])
  );

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // ROM: samples the address on the edge ending ROM_rd, shows garbage until the
  // data becomes valid MEM_LAT-1 edges later, then holds it.
  always @(posedge Clock) begin
    for (int g = 0; g < 2; g++) begin
      if (rom_rd[g] === 1'b1) begin
        if (lat_of(g) == 1) begin
          rom_data[g] <= mem[rom_addr[g]];
        end else begin
          rom_data[g]  <= ~mem[rom_addr[g]];
          pend_addr[g] <= rom_addr[g];
          pend_cnt[g]  <= lat_of(g) - 1;
        end
      end else if (pend_cnt[g] != 0) begin
        pend_cnt[g] <= pend_cnt[g] - 1;
        rom_data[g] <= (pend_cnt[g] == 1) ? mem[pend_addr[g]] : ~mem[pend_addr[g]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecount);
    end
  endtask

  task automatic model_edge(input logic rst, input logic f, input logic pl,
                            input logic [7:0] ja);
    for (int g = 0; g < 2; g++) begin
      int l;
      l = lat_of(g);
      if (rst) begin
        m_pc[g] = 8'h00; m_ra[g] = 8'h00; m_ir[g] = 16'h0000; m_start[g] = -1;
      end else begin
        if (m_start[g] >= 0 && ecount == m_start[g] + l + 1) m_ir[g] = mem[m_fa[g]];
        if (m_start[g] >= 0 && ecount == m_start[g] + l + 2) m_pc[g] = m_fa[g] + 8'd1;
        if (m_start[g] < 0 || ecount >= m_start[g] + l + 3) begin
          if (f) begin
            m_fa[g]    = pl ? ja : m_pc[g];
            if (pl) m_pc[g] = ja;
            m_ra[g]    = m_fa[g];
            m_start[g] = ecount;
          end else if (pl) begin
            m_pc[g] = ja;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 2; g++) begin
      int l, rel;
      logic act;
      l   = lat_of(g);
      act = (m_start[g] >= 0);
      rel = ecount - m_start[g];
      check($sformatf("L%0d rom_rd", l), 32'(rom_rd[g]), 32'(act && rel == 0));
      check($sformatf("L%0d ir_ld", l), 32'(ir_ld[g]), 32'(act && rel == l + 1));
      check($sformatf("L%0d busy", l), 32'(busy[g]), 32'(act && rel <= l + 1));
      check($sformatf("L%0d done", l), 32'(done[g]), 32'(act && rel == l + 2));
      check($sformatf("L%0d pc", l), 32'(pc[g]), 32'(m_pc[g]));
      check($sformatf("L%0d rom_addr", l), 32'(rom_addr[g]), 32'(m_ra[g]));
      check($sformatf("L%0d ir_data", l), 32'(ir_data[g]), 32'(m_ir[g]));
    end
  endtask

  task automatic step(input logic rst, input logic f, input logic pl, input logic [7:0] ja);
    Reset = rst; Fetch = f; PC_ld = pl; Jump_addr = ja;
    @(posedge Clock);
    ecount++;
    model_edge(rst, f, pl, ja);
    @(negedge Clock);
    compare_all();
    if (ir_ld[0] === 1'b1) begin
      ir_log.push_back(ir_data[0]);
      ir_edge.push_back(ecount);
    end
    if (rom_rd[0] === 1'b1) ra_log.push_back(rom_addr[0]);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'hFA43;
    mem[8'h01] = 16'hF0F0;
    mem[8'h02] = 16'h1234;
    mem[8'h40] = 16'hABCD;

    // Reset held with Fetch high: nothing starts.
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00);
    check("reset pc", 32'(pc[0]), 32'h0);
    check("reset busy", 32'(busy[0]), 32'h0);

    // Back-to-back fetches with Fetch held high.
    repeat (12) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("b2b count", 32'(ir_log.size()), 32'd3);
    check("b2b first ir_ld edge", 32'(ir_edge[0]), 32'd6);
    check("b2b ir0", 32'(ir_log[0]), 32'hFA43);
    check("b2b ir1", 32'(ir_log[1]), 32'hF0F0);
    check("b2b ir2", 32'(ir_log[2]), 32'h1234);
    check("b2b spacing", 32'(ir_edge[1] - ir_edge[0]), 32'd4);
    check("b2b addr1", 32'(ra_log[1]), 32'h01);
    check("b2b addr2", 32'(ra_log[2]), 32'h02);
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00);

    // Jump and fetch together.
    step(1'b0, 1'b1, 1'b1, 8'h40);
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("jump pc", 32'(pc[0]), 32'h41);
    check("jump ir", 32'(ir_data[0]), 32'hABCD);
    check("jump ir lat3", 32'(ir_data[1]), 32'hABCD);

    // PC wraps from FF to 00.
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("wrap pc", 32'(pc[0]), 32'h00);
    check("wrap pc lat3", 32'(pc[1]), 32'h00);

    // Requests while busy are dropped.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h77);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 1'b1, 8'h33);
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("ignored pc", 32'(pc[0]), 32'h01);

    // Reset during WAIT aborts the fetch.
    step(1'b0, 1'b0, 1'b1, 8'h10);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("abort ir", 32'(ir_data[0]), 32'h0);
    check("abort pc", 32'(pc[0]), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (8) step(1'b0, 1'b0, 1'b0, 8'h00);
    check("after abort ir", 32'(ir_data[0]), 32'hFA43);
    check("after abort ir lat3", 32'(ir_data[1]), 32'hFA43);

    // Random traffic.
    repeat (400) begin
      logic       r_rst, r_f, r_pl;
      logic [7:0] r_ja;
      r_rst = ($urandom % 40) == 0;
      r_f   = ($urandom % 2) == 0;
      r_pl  = ($urandom % 5) == 0;
      r_ja  = 8'($urandom);
      step(r_rst, r_f, r_pl, r_ja);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer for the processor datapath. It owns the program counter, reads 16-bit instruction words from the synchronous instruction ROM, and writes each word into the instruction register. It drives the IR's data input and its load strobe, so it sits between instruction memory and the IR. The control state machine requests each fetch with a single-cycle handshake and can redirect the PC for jumps.

## Interface
- ADDR_W, 8, PC and ROM address width
- MEM_LAT, 1, ROM read latency in cycles (legal 1..4)

- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high; reset is synchronous and active-high on the single clock Clock
- Fetch  in  1  fetch request from the control FSM, sampled only in IDLE
- PC_ld  in  1  load PC from Jump_addr, sampled only in IDLE
- Jump_addr  in  ADDR_W  jump target
- ROM_data  in  16  ROM read data
- ROM_addr  out  ADDR_W  ROM address, registered
- ROM_rd  out  1  ROM read enable, one-cycle pulse
- IR_data  out  16  word to IR DATA; holds the last fetched word
- IR_ld  out  1  IR load strobe to IR IR_id, one-cycle pulse
- Busy  out  1  high in ISSUE/WAIT/LOAD
- Done  out  1  one-cycle pulse; IR holds the new word in this cycle
- PC  out  ADDR_W  address of the next instruction to fetch

## Operation
- States:
  - IDLE: wait for a request.
  - ISSUE: ROM_rd=1, one cycle.
  - WAIT: MEM_LAT cycles, down-counter.
  - LOAD: IR_ld=1, one cycle.
- IDLE with Fetch=1, PC_ld=0:
  - ROM_addr<=PC.
  - Go to ISSUE.
- IDLE with PC_ld=1, Fetch=0:
  - PC<=Jump_addr.
  - Stay in IDLE.
- IDLE with PC_ld=1 and Fetch=1 together:
  - PC<=Jump_addr and ROM_addr<=Jump_addr.
  - Go to ISSUE, so the fetch reads the jump target.
- ISSUE→WAIT: wait counter loaded with MEM_LAT-1.
- WAIT:
  - On the last WAIT cycle (counter==0), the holding register <=ROM_data; go to LOAD.
  - Otherwise, decrement the counter.
- LOAD→IDLE:
  - PC<=PC+1, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - Done<=1 for the next cycle.
- IR_data is driven directly from the holding register, so it is stable in LOAD and afterwards.
- Fetch and PC_ld are ignored while Busy=1. They are not queued; the control FSM must wait for Done.
- Fetch held high through the Done cycle (which is in IDLE) starts the next fetch immediately.
- Reset at any cycle:
  - Aborts the current fetch and returns to IDLE.
  - IR_ld is not asserted for the aborted fetch; PC is not incremented.
- ROM contract: the ROM samples ROM_addr on the edge that ends the ROM_rd cycle. ROM_data is valid MEM_LAT-1 cycles after that edge and is held until the next read.

## Timing
- Reset values: PC=0, ROM_addr=0, ROM_rd=0, IR_data=16'h0000, IR_ld=0, Busy=0, Done=0, state=IDLE.
- Cycle numbering: Fetch sampled at edge E0.
  - ISSUE during cycle 1.
  - WAIT during cycles 2..1+MEM_LAT.
  - LOAD (IR_ld=1) during cycle 2+MEM_LAT.
  - Done during cycle 3+MEM_LAT.
- Latency from the Fetch-sampled edge to IR loaded is MEM_LAT+2 edges.
- Back-to-back throughput: one instruction per MEM_LAT+3 cycles.
- PC shows the incremented value from the Done cycle onwards.
- Busy rises in cycle 1 and falls in the Done cycle. Done and Busy are never both high.
- All outputs are registered except ROM_rd, IR_ld and Busy, which are decoded from state.

## Test plan
- Reset with Fetch=1 held: all outputs are at their reset values and state stays in IDLE. After Reset falls with ROM[0]=16'hFA43 and MEM_LAT=1:
  - IR_ld pulses 3 edges later with IR_data=16'hFA43.
  - Done follows one cycle after IR_ld; PC=1.
- Back-to-back, Fetch held high, ROM[1]=16'hF0F0, ROM[2]=16'h1234:
  - IR_data sequence is FA43, F0F0, 1234.
  - IR_ld pulses are 4 cycles apart; ROM_addr is 0, 1, 2.
- Jump: PC_ld=1 and Fetch=1 together with Jump_addr=8'h40 and ROM[0x40]=16'hABCD:
  - ROM_addr=0x40; IR_data=16'hABCD; PC=0x41 after Done.
- Wrap and ignored requests:
  - PC_ld to 8'hFF, then fetch: PC=0x00 after Done.
  - Fetch and PC_ld pulsed while Busy=1: no second ROM_rd and no PC change.
- MEM_LAT=3:
  - IR_ld occurs exactly 5 edges after Fetch is sampled.
  - IR_data captures the ROM word valid in the last WAIT cycle, not a stale earlier value.
- Reset in the WAIT cycle:
  - No IR_ld pulse and no Done; PC=0 and IR_data=0.
  - A following Fetch reads ROM[0].
